// File: rtl/adder_pkg.sv
// Shared types and helpers for the multi-cycle adder sequencer.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to index n items, never less than one.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/carry_select_adder.sv
// Combinational carry-select adder: each SIZE-bit block precomputes both carry-in cases.
module Carry_Select_Adder #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NB = WIDTH / SIZE;

  if ((WIDTH % SIZE) != 0) begin : g_bad_size
    $error("Carry_Select_Adder: WIDTH must be a multiple of SIZE");
  end

  logic [NB:0] carry_s;

  assign carry_s[0] = cin;

  for (genvar g = 0; g < NB; g++) begin : g_blk
    logic [SIZE:0] r0_s;
    logic [SIZE:0] r1_s;

    assign r0_s = {1'b0, a[g*SIZE +: SIZE]} + {1'b0, b[g*SIZE +: SIZE]};
    assign r1_s = {1'b0, a[g*SIZE +: SIZE]} + {1'b0, b[g*SIZE +: SIZE]} + {{SIZE{1'b0}}, 1'b1};

    assign sum[g*SIZE +: SIZE] = carry_s[g] ? r1_s[SIZE-1:0] : r0_s[SIZE-1:0];
    assign carry_s[g+1]        = carry_s[g] ? r1_s[SIZE]     : r0_s[SIZE];
  end

  assign cout = carry_s[NB];

endmodule

// File: rtl/multi_cycle_adder_seq.sv
// Multi-cycle WIDTH-bit add/subtract: one CHUNK-bit slice per cycle through a shared
// carry-select datapath, inter-chunk carry held in a flop, valid/ready on both sides.
module multi_cycle_adder_seq
  import adder_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int CHUNK = 32,
  parameter int SIZE  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = clog2_min1(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  if ((WIDTH % CHUNK) != 0) begin : g_bad_width
    $error("multi_cycle_adder_seq: WIDTH must be a multiple of CHUNK");
  end

  state_t             state_r;
  logic [IDX_W-1:0]   idx_r;
  logic               carry_r;
  logic [WIDTH-1:0]   op_a_r;
  logic [WIDTH-1:0]   op_b_r;
  logic [WIDTH-1:0]   s_r;
  logic               cout_r;
  logic               ovf_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic               busy_r;

  logic [CHUNK-1:0]   chunk_a_s;
  logic [CHUNK-1:0]   chunk_b_s;
  logic [CHUNK-1:0]   chunk_sum_s;
  logic               chunk_cout_s;
  logic               ovf_s;

  assign chunk_a_s = op_a_r[int'(idx_r)*CHUNK +: CHUNK];
  assign chunk_b_s = op_b_r[int'(idx_r)*CHUNK +: CHUNK];

  Carry_Select_Adder #(
    .WIDTH (CHUNK),
    .SIZE  (SIZE)
  ) u_datapath (
    .a    (chunk_a_s),
    .b    (chunk_b_s),
    .cin  (carry_r),
    .sum  (chunk_sum_s),
    .cout (chunk_cout_s)
  );

  // op_b already holds ~b for subtract, so the same sign rule covers add and subtract.
  assign ovf_s = (op_a_r[WIDTH-1] == op_b_r[WIDTH-1]) &&
                 (chunk_sum_s[CHUNK-1] != op_a_r[WIDTH-1]);

  // Sequencer FSM: operand capture, per-chunk accumulation and result handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      idx_r       <= '0;
      carry_r     <= 1'b0;
      op_a_r      <= '0;
      op_b_r      <= '0;
      s_r         <= '0;
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            op_a_r     <= a;
            op_b_r     <= sub ? ~b : b;
            carry_r    <= sub ? 1'b1 : cin;
            idx_r      <= '0;
            state_r    <= RUN;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        RUN: begin
          s_r[int'(idx_r)*CHUNK +: CHUNK] <= chunk_sum_s;
          carry_r <= chunk_cout_s;
          if (idx_r == LAST_IDX) begin
            cout_r      <= chunk_cout_s;
            ovf_r       <= ovf_s;
            idx_r       <= '0;
            state_r     <= DONE;
            out_valid_r <= 1'b1;
          end else begin
            idx_r <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b1;
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          idx_r       <= '0;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign s         = s_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_multi_cycle_adder_seq.sv
// Scoreboard bench for multi_cycle_adder_seq (WIDTH=128, CHUNK=32): directed ops push
// expected results, an independent monitor compares each new out_valid.
module tb_multi_cycle_adder_seq;

  localparam int W = 128;

  typedef struct packed {
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         cout;
  logic         ovf;
  logic         busy;

  int   total = 0;
  int   bad   = 0;
  int   results = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic prev_valid = 1'b0;

  multi_cycle_adder_seq #(.WIDTH(128), .CHUNK(32), .SIZE(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] es, input logic ec, input logic eo);
    exp_t e;
    e.s = es;
    e.cout = ec;
    e.ovf = eo;
    return e;
  endfunction

  function automatic exp_t golden_add(input logic [W-1:0] ga, input logic [W-1:0] gb);
    logic [W:0] r;
    r = {1'b0, ga} + {1'b0, gb};
    return mk(r[W-1:0], r[W], (ga[W-1] == gb[W-1]) && (r[W-1] != ga[W-1]));
  endfunction

  // Monitor: compare against the scoreboard on the first cycle of every result.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && !prev_valid) begin
        results++;
        if (exp_q.size() == 0) begin
          check("unexpected_result", {{(W-1){1'b0}}, out_valid}, {W{1'b0}});
        end else begin
          mon_e = exp_q.pop_front();
          check("result_s", s, mon_e.s);
          check("result_cout", {{(W-1){1'b0}}, cout}, {{(W-1){1'b0}}, mon_e.cout});
          check("result_ovf", {{(W-1){1'b0}}, ovf}, {{(W-1){1'b0}}, mon_e.ovf});
        end
      end
      prev_valid = out_valid;
    end
  end

  // Wait for in_ready, present one op, return just after the accepting edge.
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tcin,
                       input logic tsub, input bit push, input exp_t e);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", {W{1'b0}}, {{(W-1){1'b0}}, 1'b1});
    a = ta; b = tb_v; cin = tcin; sub = tsub; in_valid = 1'b1;
    @(posedge clk);
    if (push) exp_q.push_back(e);
    #1;
    in_valid = 1'b0;
    a = ~ta; b = ~tb_v; cin = ~tcin; sub = ~tsub;
  endtask

  logic [W-1:0] va [5];
  logic [W-1:0] vb;
  logic [W-1:0] held_s;
  int lat;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_in_ready", {{(W-1){1'b0}}, in_ready}, {{(W-1){1'b0}}, 1'b1});
    check("reset_out_valid", {{(W-1){1'b0}}, out_valid}, {W{1'b0}});
    check("reset_busy", {{(W-1){1'b0}}, busy}, {W{1'b0}});
    check("reset_s", s, {W{1'b0}});
    check("reset_cout_ovf", {{(W-2){1'b0}}, cout, ovf}, {W{1'b0}});

    // 1. full carry ripple, with latency measurement
    issue({W{1'b1}}, 128'd1, 1'b0, 1'b0, 1'b1, mk({W{1'b0}}, 1'b1, 1'b0));
    check("run_busy", {{(W-1){1'b0}}, busy}, {{(W-1){1'b0}}, 1'b1});
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) break;
    end
    check("latency", W'(lat), W'(4));

    // 2. subtract with borrow
    issue(128'd5, 128'd7, 1'b0, 1'b1, 1'b1,
          mk(128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0));
    // 3. signed overflow
    issue(128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0, 1'b0, 1'b1,
          mk(128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0, 1'b1));

    // 4. backpressure
    @(negedge clk);
    while (out_valid || busy) @(negedge clk);
    out_ready = 1'b0;
    issue(128'h0000_0001_FFFF_FFFF_0000_0000_FFFF_FFFF, 128'd1, 1'b0, 1'b0, 1'b1,
          mk(128'h0000_0001_FFFF_FFFF_0000_0001_0000_0000, 1'b0, 1'b0));
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    held_s = s;
    a = 128'd99; b = 128'd1; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_valid", {{(W-1){1'b0}}, out_valid}, {{(W-1){1'b0}}, 1'b1});
      check("bp_s_stable", s, 128'h0000_0001_FFFF_FFFF_0000_0001_0000_0000);
      check("bp_in_ready", {{(W-1){1'b0}}, in_ready}, {W{1'b0}});
    end
    check("bp_held_s", held_s, 128'h0000_0001_FFFF_FFFF_0000_0001_0000_0000);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", {{(W-1){1'b0}}, out_valid}, {W{1'b0}});
    check("bp_release_ready", {{(W-1){1'b0}}, in_ready}, {{(W-1){1'b0}}, 1'b1});

    // 5. reset after chunk 2 written; this op is discarded
    issue(128'h1111_2222_3333_4444_5555_6666_7777_8888, 128'h1, 1'b0, 1'b0, 1'b0,
          mk({W{1'b0}}, 1'b0, 1'b0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_s", s, {W{1'b0}});
    check("rst_mid_valid", {{(W-1){1'b0}}, out_valid}, {W{1'b0}});
    check("rst_mid_busy", {{(W-1){1'b0}}, busy}, {W{1'b0}});
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_rel_ready", {{(W-1){1'b0}}, in_ready}, {{(W-1){1'b0}}, 1'b1});
    issue({W{1'b0}}, {W{1'b0}}, 1'b1, 1'b0, 1'b1, mk(128'd1, 1'b0, 1'b0));

    // 6. back-to-back with in_valid and out_ready held high
    va[0] = 128'h0;
    va[1] = {W{1'b1}};
    va[2] = 128'h8000_0000_0000_0000_0000_0000_0000_0000;
    va[3] = 128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
    va[4] = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    vb    = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 20) begin
        @(posedge clk);
        n++;
        @(negedge clk);
      end
      if (i > 0) check("b2b_period", W'(n + 1), W'(6));
      a = va[i]; b = vb; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      exp_q.push_back(golden_add(va[i], vb));
    end
    #1;
    in_valid = 1'b0;
    repeat (12) @(negedge clk);

    check("results_seen", W'(results), W'(10));
    check("queue_empty", W'(exp_q.size()), {W{1'b0}});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
